// File: rtl/pht_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pht_access_ctrl_pkg
//  Shared definitions for the PHT access controller:
//   - 2-bit saturating counter encodings
//   - controller FSM state codes
//   - sat_update(): saturating counter step used by the read-modify-write path
// ---------------------------------------------------------------------------
package pht_access_ctrl_pkg;

    // Counter encodings (MSB is the prediction)
    localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

    // Controller FSM state codes
    localparam logic [1:0] ST_INIT   = 2'b00;
    localparam logic [1:0] ST_IDLE   = 2'b01;
    localparam logic [1:0] ST_UPD_WR = 2'b10;

    // Move a counter one step towards the observed outcome, saturating at
    // strongly-not-taken and strongly-taken.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                res = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                res = ctr - 2'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// ---------------------------------------------------------------------------
// pht_upd_fifo
//  In-order queue of pending PHT counter updates.
//  Ports:
//   clk, rst     clock, asynchronous active-low reset
//   flush        synchronous flush; empties the queue (wins over push/pop)
//   push         enqueue push_data (ignored when full)
//   push_data    entry to enqueue
//   pop          dequeue head (ignored when empty)
//   head_data    current head entry (valid when !empty)
//   full, empty  status flags
//  Pointers carry one extra wrap bit so full and empty are distinguishable
//  without a separate occupancy counter.
// ---------------------------------------------------------------------------
module pht_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      head_q, head_d;
    logic [AW:0]      tail_q, tail_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty     = (head_q == tail_q);
    assign full      = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
    assign head_data = mem_q[head_q[AW-1:0]];

    always_comb begin
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (do_push) begin
                tail_d = tail_q + 1'b1;
            end
            if (do_pop) begin
                head_d = head_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pht_access_ctrl.sv
// ---------------------------------------------------------------------------
// pht_access_ctrl
//  Access controller for a single-port, synchronous-read PHT RAM of 2-bit
//  saturating counters. Arbitrates fetch lookups against queued retire
//  updates (applied as read-modify-write) and sequences PHT initialisation
//  after reset and after a soft clear.
//  Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   clear_req                flush update queue and re-initialise the PHT
//   pred_req/pred_index      lookup request; pred_ready = accepted this cycle
//   pred_valid/pred_taken    lookup result, one cycle after acceptance
//   upd_valid/upd_index/
//   upd_taken/upd_ready      update push handshake
//   init_done                PHT initialised (level)
//   pht_en/pht_we/pht_addr/
//   pht_wdata/pht_rdata      RAM interface (read data one cycle after read)
//  Optional feature macro PHT_CTRL_STATS_EN adds stat_lookups, stat_updates
//  and stat_stall (wrapping 32-bit counters, cleared by rst only).
// ---------------------------------------------------------------------------
module pht_access_ctrl
    import pht_access_ctrl_pkg::*;
#(
    parameter int         PHT_DEPTH  = 6,
    parameter int         UQ_DEPTH   = 4,
    parameter logic [1:0] INIT_STATE = CTR_WT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_req,
    input  logic                 pred_req,
    input  logic [PHT_DEPTH-1:0] pred_index,
    output logic                 pred_ready,
    output logic                 pred_valid,
    output logic                 pred_taken,
    input  logic                 upd_valid,
    input  logic [PHT_DEPTH-1:0] upd_index,
    input  logic                 upd_taken,
    output logic                 upd_ready,
    output logic                 init_done,
    output logic                 pht_en,
    output logic                 pht_we,
    output logic [PHT_DEPTH-1:0] pht_addr,
    output logic [1:0]           pht_wdata,
    input  logic [1:0]           pht_rdata
`ifdef PHT_CTRL_STATS_EN
    ,
    output logic [31:0]          stat_lookups,
    output logic [31:0]          stat_updates,
    output logic [31:0]          stat_stall
`endif
);

    localparam logic [PHT_DEPTH-1:0] LAST_IDX = '1;

    logic [1:0]           state_q, state_d;
    logic [PHT_DEPTH-1:0] ptr_q, ptr_d;
    logic                 pred_valid_q, pred_valid_d;
    logic                 init_done_q, init_done_d;

    logic                 ram_en;
    logic                 ram_we;
    logic                 fifo_pop;
    logic                 fifo_flush;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [PHT_DEPTH:0]   head_data;
    logic [PHT_DEPTH-1:0] head_index;
    logic                 head_taken;

    assign head_index = head_data[PHT_DEPTH:1];
    assign head_taken = head_data[0];

    pht_upd_fifo #(
        .DEPTH (UQ_DEPTH),
        .WIDTH (PHT_DEPTH + 1)
    ) u_upd_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (upd_valid),
        .push_data ({upd_index, upd_taken}),
        .pop       (fifo_pop),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        pred_valid_d = 1'b0;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        pht_addr     = '0;
        pht_wdata    = '0;

        case (state_q)
            ST_INIT: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                pht_addr  = ptr_q;
                pht_wdata = INIT_STATE;
                if (clear_req) begin
                    // Restart the sweep; the current write is harmless.
                    ptr_d      = '0;
                    fifo_flush = 1'b1;
                end else if (ptr_q == LAST_IDX) begin
                    ptr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end

            ST_IDLE: begin
                if (pred_req && !fifo_full) begin
                    ram_en       = 1'b1;
                    pht_addr     = pred_index;
                    pred_valid_d = 1'b1;
                end else if (!fifo_empty && !clear_req) begin
                    // Read phase of the read-modify-write; the head entry stays
                    // in place until the write so its fields remain available.
                    ram_en   = 1'b1;
                    pht_addr = head_index;
                    state_d  = ST_UPD_WR;
                end
                if (clear_req) begin
                    fifo_flush = 1'b1;
                    ptr_d      = '0;
                    state_d    = ST_INIT;
                end
            end

            ST_UPD_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                pht_addr  = head_index;
                pht_wdata = sat_update(pht_rdata, head_taken);
                fifo_pop  = 1'b1;
                state_d   = ST_IDLE;
                // The write above always completes; a clear only takes effect
                // after it, flushing whatever is left behind it.
                if (clear_req) begin
                    fifo_flush = 1'b1;
                    ptr_d      = '0;
                    state_d    = ST_INIT;
                end
            end

            default: begin
                fifo_flush = 1'b1;
                ptr_d      = '0;
                state_d    = ST_INIT;
            end
        endcase

        // init_done is high in every cycle the controller is out of INIT.
        init_done_d = (state_d != ST_INIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            ptr_q        <= '0;
            pred_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pred_valid_q <= pred_valid_d;
            init_done_q  <= init_done_d;
        end
    end

    // The FSM sits in INIT while reset is held; keep the RAM quiet until release.
    assign pht_en     = ram_en & rst;
    assign pht_we     = ram_we & rst;
    assign pred_ready = (state_q == ST_IDLE) && !fifo_full;
    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_valid_q & pht_rdata[1];
    assign upd_ready  = !fifo_full;
    assign init_done  = init_done_q;

`ifdef PHT_CTRL_STATS_EN
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_updates_q, stat_updates_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_lookups_d = stat_lookups_q + {31'd0, (pred_req && pred_ready)};
        stat_updates_d = stat_updates_q + {31'd0, (state_q == ST_UPD_WR)};
        stat_stall_d   = stat_stall_q + {31'd0, (pred_req && !pred_ready)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_lookups_q <= '0;
            stat_updates_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            stat_lookups_q <= stat_lookups_d;
            stat_updates_q <= stat_updates_d;
            stat_stall_q   <= stat_stall_d;
        end
    end

    assign stat_lookups = stat_lookups_q;
    assign stat_updates = stat_updates_q;
    assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_pht_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pht_access_ctrl
//  Randomised and directed stimulus for pht_access_ctrl, checked against a
//  behavioural model: an array of counter values, a queue of pending updates
//  and an expected initialisation sweep, all derived from the block's rules.
// ---------------------------------------------------------------------------
module tb_pht_access_ctrl;

    localparam int         PD     = 6;
    localparam int         NENT   = 64;
    localparam int         UQ     = 4;
    localparam logic [1:0] INIT_V = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req;
    logic          pred_req;
    logic [PD-1:0] pred_index;
    logic          pred_ready;
    logic          pred_valid;
    logic          pred_taken;
    logic          upd_valid;
    logic [PD-1:0] upd_index;
    logic          upd_taken;
    logic          upd_ready;
    logic          init_done;
    logic          pht_en;
    logic          pht_we;
    logic [PD-1:0] pht_addr;
    logic [1:0]    pht_wdata;
    logic [1:0]    pht_rdata;
`ifdef PHT_CTRL_STATS_EN
    logic [31:0]   stat_lookups;
    logic [31:0]   stat_updates;
    logic [31:0]   stat_stall;
`endif

    always #5 clk = ~clk;

    pht_access_ctrl #(
        .PHT_DEPTH  (PD),
        .UQ_DEPTH   (UQ),
        .INIT_STATE (INIT_V)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .pred_req   (pred_req),
        .pred_index (pred_index),
        .pred_ready (pred_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .upd_valid  (upd_valid),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .init_done  (init_done),
        .pht_en     (pht_en),
        .pht_we     (pht_we),
        .pht_addr   (pht_addr),
        .pht_wdata  (pht_wdata),
        .pht_rdata  (pht_rdata)
`ifdef PHT_CTRL_STATS_EN
        ,
        .stat_lookups (stat_lookups),
        .stat_updates (stat_updates),
        .stat_stall   (stat_stall)
`endif
    );

    // Single-port synchronous-read RAM
    logic [1:0] ram [NENT];
    always @(posedge clk) begin
        if (pht_en && !pht_we) pht_rdata <= ram[pht_addr];
        if (pht_en && pht_we)  ram[pht_addr] <= pht_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [PD-1:0] idx;
        logic          taken;
    } upd_t;

    upd_t       mq[$];
    logic [1:0] m_pht [NENT];
    bit         m_in_init  = 1'b1;
    int         m_init_cnt = 0;
    bit         m_init_done = 1'b0;
    bit         m_pv = 1'b0;
    bit         m_pt = 1'b0;
    int         m_lookups = 0;
    int         m_updates = 0;
    int         m_stall   = 0;

    function automatic logic [1:0] step(input logic [1:0] c, input logic t);
        int v;
        v = int'(c);
        if (t) v = (v == 3) ? 3 : v + 1;
        else   v = (v == 0) ? 0 : v - 1;
        return v[1:0];
    endfunction

    always @(negedge clk) begin
        upd_t e;
        logic [1:0] nv;
        if (!rst) begin
            check_eq("rst_pred_ready", pred_ready, 0);
            check_eq("rst_pred_valid", pred_valid, 0);
            check_eq("rst_init_done", init_done, 0);
            check_eq("rst_upd_ready", upd_ready, 1);
            check_eq("rst_pht_en", pht_en, 0);
            check_eq("rst_pht_we", pht_we, 0);
            mq.delete();
            m_in_init   = 1'b1;
            m_init_cnt  = 0;
            m_init_done = 1'b0;
            m_pv        = 1'b0;
            m_lookups   = 0;
            m_updates   = 0;
            m_stall     = 0;
        end else begin
            check_eq("init_done", init_done, m_init_done);
            check_eq("pred_valid", pred_valid, m_pv);
            if (m_pv) check_eq("pred_taken", pred_taken, m_pt);
            check_eq("upd_ready", upd_ready, mq.size() < UQ);
            if (m_in_init || mq.size() == UQ) check_eq("pred_ready_blocked", pred_ready, 0);
            if (pred_req && !pred_ready) m_stall++;
            m_pv = 1'b0;

            if (m_in_init) begin
                check_eq("init_we", {pht_en, pht_we}, 2'b11);
                check_eq("init_addr", pht_addr, m_init_cnt);
                check_eq("init_wdata", pht_wdata, INIT_V);
                m_pht[m_init_cnt] = INIT_V;
                if (clear_req) begin
                    m_init_cnt = 0;
                end else if (m_init_cnt == NENT - 1) begin
                    m_in_init   = 1'b0;
                    m_init_done = 1'b1;
                end else begin
                    m_init_cnt++;
                end
            end else begin
                if (pred_req && pred_ready) begin
                    check_eq("lookup_rd", {pht_en, pht_we}, 2'b10);
                    check_eq("lookup_addr", pht_addr, pred_index);
                    m_pv = 1'b1;
                    m_pt = m_pht[pred_index][1];
                    m_lookups++;
                end
                if (pht_en && pht_we) begin
                    if (mq.size() == 0) begin
                        check_eq("spurious_write", 1, 0);
                    end else begin
                        e  = mq.pop_front();
                        nv = step(m_pht[e.idx], e.taken);
                        check_eq("upd_addr", pht_addr, e.idx);
                        check_eq("upd_wdata", pht_wdata, nv);
                        m_pht[e.idx] = nv;
                        m_updates++;
                    end
                end
                if (clear_req) begin
                    m_in_init   = 1'b1;
                    m_init_cnt  = 0;
                    m_init_done = 1'b0;
                end
            end

            if (upd_valid && upd_ready) begin
                e.idx   = upd_index;
                e.taken = upd_taken;
                mq.push_back(e);
            end
            if (clear_req) mq.delete();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        clear_req = 1'b0;
        pred_req  = 1'b0;
        upd_valid = 1'b0;
    endtask

    task automatic wait_init();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (init_done) break;
        end
        check_eq("init_wait", init_done, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mq.size() == 0) break;
        end
        check_eq("drain", mq.size(), 0);
    endtask

    task automatic do_lookup(input logic [PD-1:0] idx);
        @(posedge clk); #1;
        pred_req   = 1'b1;
        pred_index = idx;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pred_ready) break;
        end
        check_eq("lookup_accept", pred_ready, 1);
        @(posedge clk); #1;
        pred_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_push(input logic [PD-1:0] idx, input logic t);
        @(posedge clk); #1;
        upd_valid = 1'b1;
        upd_index = idx;
        upd_taken = t;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (upd_ready) break;
        end
        check_eq("push_accept", upd_ready, 1);
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        idle_inputs();
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst        = 1'b0;
        idle_inputs();
        pred_index = '0;
        upd_index  = '0;
        upd_taken  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_init();

        // Lookup, single not-taken update, saturation at strongly taken
        do_lookup(6'd5);
        do_push(6'd5, 1'b0);
        drain();
        do_lookup(6'd5);
        for (int k = 0; k < 3; k++) do_push(6'd9, 1'b1);
        drain();
        do_lookup(6'd9);

        // Lookups held while the queue fills: updates stall behind lookups
        @(posedge clk); #1;
        pred_req = 1'b1;
        for (int k = 0; k < UQ; k++) begin
            pred_index = 6'($urandom_range(0, NENT - 1));
            upd_valid  = 1'b1;
            upd_index  = 6'(20 + k);
            upd_taken  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        upd_valid = 1'b0;
        @(negedge clk);
        check_eq("full_upd_ready", upd_ready, 0);
        check_eq("full_pred_ready", pred_ready, 0);
        repeat (10) @(posedge clk);
        #1 pred_req = 1'b0;
        drain();

        // Clear while an update write is in flight
        do_push(6'd12, 1'b0);
        do_push(6'd13, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pht_en && !pht_we) break;
        end
        @(posedge clk); #1;
        clear_req = 1'b1;
        @(negedge clk);
        check_eq("clr_write_busy", pht_we, 1);
        @(posedge clk); #1;
        clear_req = 1'b0;
        @(negedge clk);
        check_eq("clr_queue_empty", mq.size(), 0);
        wait_init();
        do_lookup(6'd12);

        // Random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 299) == 0) begin
                idle_inputs();
                clear_req = 1'b1;
            end else begin
                clear_req  = 1'b0;
                pred_req   = ($urandom_range(0, 99) < 50);
                pred_index = 6'($urandom_range(0, 7));
                upd_valid  = ($urandom_range(0, 99) < 40);
                upd_index  = 6'($urandom_range(0, 7));
                upd_taken  = 1'($urandom_range(0, 1));
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        wait_init();
        drain();

        // Reset in the middle of an initialisation sweep
        do_clear();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_in_init && pht_we && pht_addr == 6'd30) break;
        end
        check_eq("rst_at_30", pht_addr, 30);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("restart_addr", pht_addr, 0);
        wait_init();
        do_push(6'd3, 1'b1);
        drain();
        do_lookup(6'd3);
        repeat (3) @(negedge clk);

`ifdef PHT_CTRL_STATS_EN
        check_eq("stat_lookups", stat_lookups, m_lookups);
        check_eq("stat_updates", stat_updates, m_updates);
        check_eq("stat_stall", stat_stall, m_stall);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
